// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, timing defaults and
// the host command bytes used by the memory-mapped I/O logic.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // 100 us inhibit and 20 ms watchdog at a 50 MHz CPU clock
  localparam int PS2_INHIBIT_CYCLES_DEF = 5000;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 1000000;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a falling-edge
// detect on the synchronized clock. Shared by the receiver and transmitter.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  logic clk_meta;
  logic data_meta;
  logic clk_prev;

  // synchronizer chain; idle bus level is high, so reset to 1 to avoid a false edge
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out
// {stop, parity, data} on device clock falls, then check the device ACK.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready; both lines released
// INHIBIT    | clock held low for INHIBIT_CYCLES
// REQ        | start bit (data low), clock released, wait first device fall
// SHIFT      | presenting D0..D7, parity, stop on successive falls
// ACK        | stop presented; sample device ACK on the 11th fall
// WAIT_IDLE  | ACK seen; wait for clock and data both high, then done
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  ps2_tx_state_e state, next_state;

  logic          clk_sync, data_sync, fall;
  logic [9:0]    frame;
  logic [3:0]    idx;
  logic [3:0]    idx_pres;
  logic [IW-1:0] inh_cnt;
  logic          accept;
  logic          tmo;

  logic clk_oe_d, data_oe_d, done_d, err_d, ready_d;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .fall       (fall)
  );

  assign accept = start && ready && (state == ST_IDLE);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // watchdog: reloaded throughout INHIBIT so it starts fresh on clock release,
  // then counts down and holds at zero
  always_ff @(posedge clk) begin
    if (reset)
      tmo_cnt <= '0;
    else if (state == ST_INHIBIT)
      tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (tmo_cnt != '0)
      tmo_cnt <= tmo_cnt - 1'b1;
  end

  assign tmo = (state inside {ST_REQ, ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) && (tmo_cnt == '0);
`else
  assign tmo = 1'b0;
`endif

  // frame latch, inhibit timer and bit index
  always_ff @(posedge clk) begin
    if (reset) begin
      frame   <= '0;
      inh_cnt <= '0;
      idx     <= '0;
    end else begin
      if (accept) begin
        frame   <= {1'b1, odd_parity(tx_data), tx_data};
        inh_cnt <= IW'(INHIBIT_CYCLES - 1);
      end else if (state == ST_INHIBIT && inh_cnt != '0) begin
        inh_cnt <= inh_cnt - 1'b1;
      end
      if (fall && (state == ST_REQ || state == ST_SHIFT))
        idx <= idx_pres;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // next-state logic; a timeout overrides a coincident fall
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:      if (accept) next_state = ST_INHIBIT;
      ST_INHIBIT:   if (inh_cnt == '0) next_state = ST_REQ;
      ST_REQ: begin
        if (tmo)       next_state = ST_IDLE;
        else if (fall) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tmo)                       next_state = ST_IDLE;
        else if (fall && idx == 4'd8)  next_state = ST_ACK;
      end
      ST_ACK: begin
        if (tmo)       next_state = ST_IDLE;
        else if (fall) next_state = data_sync ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (tmo)                        next_state = ST_IDLE;
        else if (clk_sync && data_sync) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // next output values, derived from the upcoming state and this cycle's events
  always_comb begin
    idx_pres  = (state == ST_REQ) ? 4'd0 : 4'(idx + 4'd1);
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    unique case (next_state)
      ST_INHIBIT: clk_oe_d  = 1'b1;
      ST_REQ:     data_oe_d = 1'b1;
      ST_SHIFT:   data_oe_d = fall ? ~frame[idx_pres] : ps2_data_oe;
      default:    data_oe_d = 1'b0;
    endcase
    err_d   = tmo || (state == ST_ACK && fall && data_sync);
    done_d  = !tmo && (state == ST_WAIT_IDLE) && clk_sync && data_sync;
    ready_d = (next_state == ST_IDLE) && !done_d && !err_d;
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      ready       <= ready_d;
      busy        <= ~ready_d;
      done        <= done_d;
      err         <= err_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
    end
  end

endmodule
